alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port in_valid  input  1  instruction offered.
REQ-004 SHALL have port in_ready  output  1  sequencer can accept an instruction this cycle.
REQ-005 SHALL have port in_instr  input  32  instruction word; [31:26] opsel, [25:22] rd, [21:18] rs1, [17] useimm, [15:12] rs2, [15:0] imm.
REQ-006 SHALL have port alu_opsel  output  6  opsel driven to the registered ALU.
REQ-007 SHALL have ports alu_A and alu_B  output  32 each  ALU operands.
REQ-008 SHALL have port alu_out  input  32  ALU result, registered inside the ALU, valid one cycle after operands are presented.
REQ-009 SHALL have port wb_valid  output  1  writeback pulse.
REQ-010 SHALL have port wb_rd  output  4  writeback destination register.
REQ-011 SHALL have port wb_data  output  32  value written to wb_rd.
REQ-012 SHALL have ports dbg_addr  input  4  and dbg_data  output  32  combinational register-file read.

Function
REQ-013 SHALL contain a 16 x 32 register file; r0 reads 0, writes to r0 ignored.
REQ-014 SHALL implement FSM IDLE -> ISSUE -> WB -> IDLE; no other states.
REQ-015 IDLE: in_ready=1; in_valid=1 at a rising edge latches in_instr, goes to ISSUE; in_valid=0 stays IDLE.
REQ-016 ISSUE: in_ready=0; alu_opsel=latched opsel, alu_A=rf[rs1], alu_B = useimm ? sign-extended imm[15:0] : rf[rs2]; next state WB.
REQ-017 WB: in_ready=0; wb_valid=1, wb_rd=rd; rf[rd] updated at the edge ending WB; next state IDLE.
REQ-018 wb_data SHALL be alu_out, except opsel=6'd11 (MVHI): wb_data={alu_out[31:16], rf[rd][15:0]}, lower half of rd preserved.
REQ-019 Comparison ops (opsel[4]=1) and address op (opsel[5]=1) SHALL pass alu_out unmodified.
REQ-020 Outside ISSUE, alu_opsel, alu_A, alu_B SHALL be 0; outside WB, wb_valid=0, wb_rd=0, wb_data=0.
REQ-021 Latency: acceptance edge to register-file update = 2 cycles; throughput one instruction per 3 cycles.
REQ-022 Operand reads in ISSUE SHALL see writes completed by the previous instruction's WB (no forwarding needed; sequential FSM guarantees ordering).
REQ-023 dbg_data SHALL reflect rf[dbg_addr] combinationally, including a write in the same cycle only after the edge.
REQ-024 in_instr changes while not in IDLE SHALL have no effect.

Reset
REQ-025 reset=1 SHALL immediately force state IDLE, clear all 16 registers, all outputs 0 except in_ready.
REQ-026 in_ready SHALL be 0 while reset=1 and 1 in the first cycle after deassertion.
REQ-027 Reset during ISSUE or WB SHALL discard the instruction; no register-file write occurs.

Verification
REQ-028 Reset then dbg_addr sweep 0..15 -> dbg_data=0 for all; in_ready=1 after reset release.
REQ-029 Issue ADD r1=r0+imm 0x0005 (useimm=1), then ADD r2=r1+imm 0xFFFF -> r1=5, r2=4; wb_valid pulses exactly one cycle each, 3 cycles apart.
REQ-030 r3=0x0000ABCD, issue MVHI rd=r3, imm=0x1234 -> r3=0x1234ABCD.
REQ-031 r4=3, r5=7, opsel LT (6'b010010) rd=r6, rs1=r4, rs2=r5 -> r6=1; opsel 6'b100000 rd=r7, rs1=r4, imm 2 -> r7=11.
REQ-032 Issue write to r0 with imm 0x00FF -> wb_valid=1, wb_rd=0, dbg r0 still 0.
REQ-033 Assert reset during WB of ADD r8=imm 9 -> r8=0, FSM IDLE, wb_valid=0 at reset.

Source files
------------

// File: rtl/alu_sequencer.sv
// Three-state sequencer: latches one instruction, presents operands to an external
// registered ALU, then writes the ALU result back into a 16x32 register file.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [5:0]  alu_opsel,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  input  logic [31:0] alu_out,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [5:0] OP_MVHI = 6'd11;

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  state_t             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [15:0][31:0]  rf_q, rf_d;

  logic [5:0]  opsel;
  logic [3:0]  rd, rs1, rs2;
  logic        useimm;
  logic [15:0] imm;
  logic        unused_bit16;

  assign opsel        = instr_q[31:26];
  assign rd           = instr_q[25:22];
  assign rs1          = instr_q[21:18];
  assign useimm       = instr_q[17];
  assign rs2          = instr_q[15:12];
  assign imm          = instr_q[15:0];
  assign unused_bit16 = instr_q[16];

  // r0 is never written, so reading it always yields the reset value of 0.
  assign dbg_data = rf_q[dbg_addr];

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    in_ready  = 1'b0;
    alu_opsel = '0;
    alu_A     = '0;
    alu_B     = '0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    case (state_q)
      IDLE: begin
        in_ready = ~reset;
        if (in_valid) begin
          instr_d = in_instr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        alu_opsel = opsel;
        alu_A     = rf_q[rs1];
        alu_B     = useimm ? {{16{imm[15]}}, imm} : rf_q[rs2];
        state_d   = WB;
      end
      WB: begin
        wb_valid = 1'b1;
        wb_rd    = rd;
        // MVHI only replaces the upper half; the destination keeps its low half.
        wb_data  = (opsel == OP_MVHI) ? {alu_out[31:16], rf_q[rd][15:0]} : alu_out;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_valid && (wb_rd != 4'd0)) rf_d[wb_rd] = wb_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      rf_q    <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rf_q    <= rf_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed checks of alu_sequencer against an array-based register
// model, with a small registered ALU stand-in driving alu_out.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [5:0]  alu_opsel;
  logic [31:0] alu_A, alu_B;
  logic [31:0] alu_out = '0;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_wb = 0;
  logic [31:0] m_rf [16];

  alu_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .alu_opsel(alu_opsel), .alu_A(alu_A), .alu_B(alu_B),
    .alu_out(alu_out), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_fn(logic [5:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      6'd0:      return a + b;
      6'd1:      return a - b;
      6'd2:      return a ^ b;
      6'd11:     return b << 16;
      6'b010010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'b100000: return a + (b << 2);
      default:   return a & b;
    endcase
  endfunction

  // External registered ALU: result one cycle after operands.
  always @(posedge clk) alu_out <= alu_fn(alu_opsel, alu_A, alu_B);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(logic [5:0] op, logic [3:0] rd, logic [3:0] rs1,
                                     logic ui, logic [15:0] imm);
    return {op, rd, rs1, ui, 1'b0, imm};
  endfunction

  // Architectural result of one instruction from the model register file.
  function automatic logic [31:0] ref_exec(logic [31:0] ins);
    logic [31:0] a, b, r, old;
    a   = m_rf[ins[21:18]];
    b   = ins[17] ? {{16{ins[15]}}, ins[15:0]} : m_rf[ins[15:12]];
    old = m_rf[ins[25:22]];
    r   = alu_fn(ins[31:26], a, b);
    if (ins[31:26] == 6'd11) r = {r[31:16], old[15:0]};
    return r;
  endfunction

  // Called at a negedge while idle; returns at the negedge the sequencer is idle again.
  task automatic run_instr(input logic [31:0] ins, input bit check_rd = 1);
    logic [31:0] exp;
    int waited;
    waited = 0;
    while (!in_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("ready_timeout", {31'b0, in_ready}, 32'd1);
    exp = ref_exec(ins);
    in_valid = 1'b1;
    in_instr = ins;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = $urandom;
    @(negedge clk);
    chk("issue_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("issue_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("wb_rd", {28'b0, wb_rd}, {28'b0, ins[25:22]});
    chk("wb_data", wb_data, exp);
    last_wb = cyc;
    @(negedge clk);
    chk("wb_pulse_end", {31'b0, wb_valid}, 32'd0);
    if (ins[25:22] != 4'd0) m_rf[ins[25:22]] = exp;
    if (check_rd) begin
      dbg_addr = ins[25:22];
      #1 chk("rf_rd", dbg_data, m_rf[ins[25:22]]);
    end
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = i[3:0];
      #1 chk(tag, dbg_data, m_rf[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ops[6] = '{0, 1, 2, 11, 18, 32};
    int t0;
    logic [31:0] ins;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; dbg_addr = '0;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_alu_A", alu_A, 32'd0);
    reset = 1'b0;
    #1 chk("ready_after_rst", {31'b0, in_ready}, 32'd1);
    sweep("rst_rf");
    @(negedge clk);

    // ADD chain, with back-to-back spacing of writebacks
    run_instr(mk(6'd0, 4'd1, 4'd0, 1'b1, 16'h0005));
    t0 = last_wb;
    run_instr(mk(6'd0, 4'd2, 4'd1, 1'b1, 16'hFFFF));
    chk("wb_spacing", last_wb - t0, 32'd3);
    chk("r1", m_rf[1], 32'd5);
    chk("r2", m_rf[2], 32'd4);

    // MVHI keeps the low half
    run_instr(mk(6'd0, 4'd3, 4'd0, 1'b1, 16'h55E6));
    run_instr(mk(6'd0, 4'd3, 4'd3, 1'b1, 16'h55E7));
    run_instr(mk(6'd11, 4'd3, 4'd0, 1'b1, 16'h1234));
    dbg_addr = 4'd3;
    #1 chk("mvhi_r3", dbg_data, 32'h1234ABCD);

    // Compare and address ops
    run_instr(mk(6'd0, 4'd4, 4'd0, 1'b1, 16'd3));
    run_instr(mk(6'd0, 4'd5, 4'd0, 1'b1, 16'd7));
    run_instr(mk(6'b010010, 4'd6, 4'd4, 1'b0, {4'd5, 12'h000}));
    dbg_addr = 4'd6;
    #1 chk("lt_r6", dbg_data, 32'd1);
    run_instr(mk(6'b100000, 4'd7, 4'd4, 1'b1, 16'd2));
    dbg_addr = 4'd7;
    #1 chk("addr_r7", dbg_data, 32'd11);

    // Write to r0 is signalled but dropped
    run_instr(mk(6'd0, 4'd0, 4'd0, 1'b1, 16'h00FF));
    dbg_addr = 4'd0;
    #1 chk("r0_zero", dbg_data, 32'd0);

    // Randomized instruction stream
    for (int k = 0; k < 40; k++) begin
      ins = mk(ops[$urandom_range(0, 5)][5:0], 4'($urandom), 4'($urandom),
               1'($urandom), 16'($urandom));
      run_instr(ins);
    end
    sweep("rand_rf");

    // Reset arriving during WB discards the write
    in_valid = 1'b1;
    in_instr = mk(6'd0, 4'd8, 4'd0, 1'b1, 16'd9);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_wb_valid", {31'b0, wb_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_wb_valid_async", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_data_async", wb_data, 32'd0);
    chk("rst_ready_async", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    @(negedge clk);
    reset = 1'b0;
    #1 chk("idle_after_rst", {31'b0, in_ready}, 32'd1);
    dbg_addr = 4'd8;
    #1 chk("r8_discarded", dbg_data, 32'd0);
    sweep("rst2_rf");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
